// File: rtl/stopwatch_top.sv
// MM:SS stopwatch: prescaler turns clk into one-second ticks; IDLE/RUNNING/PAUSED control FSM.
// One-edge latency from a sampled request to status; outputs are registered; there is no backpressure.
module stopwatch_top #(
    parameter int TICKS_PER_SEC = 500,
    parameter int MAX_MIN       = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       reset,
    output logic [6:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] status
);
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [6:0]    MIN_LAST   = 7'(MAX_MIN);
    localparam logic [5:0]    SEC_LAST   = 6'd59;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic [6:0]    min_q, min_d;
    logic          tick;

    // Priority reset > stop > start; holding a button is idempotent.
    always_comb begin
        state_d = state_q;
        if (reset) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (!stop && start) state_d = S_RUN;
                S_RUN:   if (stop) state_d = S_PAUSE;
                S_PAUSE: if (!stop && start) state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign tick = (state_q == S_RUN) && (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        if (reset || state_q == S_IDLE) begin
            presc_d = '0;
            sec_d   = '0;
            min_d   = '0;
        end else if (state_q == S_RUN) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                if (sec_q != SEC_LAST) begin
                    sec_d = sec_q + 6'd1;
                end else begin
                    sec_d = '0;
                    min_d = (min_q == MIN_LAST) ? 7'd0 : min_q + 7'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            sec_q   <= '0;
            min_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
        end
    end

    assign minutes = min_q;
    assign seconds = sec_q;
    assign status  = state_q;
endmodule

// File: tb/tb_stopwatch_top.sv
// Directed bench for stopwatch_top with a one-second period of four clocks.
module tb_stopwatch_top;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic [1:0] status;

    int checks = 0;
    int errors = 0;

    stopwatch_top #(.TICKS_PER_SEC(4), .MAX_MIN(99)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stop   (stop),
        .reset  (reset),
        .minutes(minutes),
        .seconds(seconds),
        .status (status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stop;
        logic       reset;
        logic [1:0] st;
        logic [6:0] mn;
        logic [5:0] sc;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [1:0] st, input logic [6:0] mn,
                             input logic [5:0] sc);
        check({name, ".status"}, 32'(status), 32'(st));
        check({name, ".minutes"}, 32'(minutes), 32'(mn));
        check({name, ".seconds"}, 32'(seconds), 32'(sc));
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic s, input logic p, input logic r);
        start = s;
        stop  = p;
        reset = r;
        edges(1);
        start = 1'b0;
        stop  = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        // start, stop, reset -> expected status, minutes, seconds after the edge
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 2'b00, 7'd0, 6'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 2'b00, 7'd0, 6'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'b01, 7'd0, 6'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 2'b01, 7'd0, 6'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 2'b01, 7'd0, 6'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'b01, 7'd0, 6'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'b01, 7'd0, 6'd1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 2'b10, 7'd0, 6'd1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 2'b10, 7'd0, 6'd1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'b10, 7'd0, 6'd1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 2'b01, 7'd0, 6'd1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 2'b01, 7'd0, 6'd1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 2'b01, 7'd0, 6'd1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 2'b01, 7'd0, 6'd2};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 2'b00, 7'd0, 6'd0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 2'b01, 7'd0, 6'd0};

        // Reset state and idle hold
        #2;
        check_all("in_reset", 2'b00, 7'd0, 6'd0);
        edges(2);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            edges(1);
            check_all("idle_hold", 2'b00, 7'd0, 6'd0);
        end

        // Table: held buttons, start+stop, pause/resume fraction, reset priority
        for (int i = 0; i < 16; i++) begin
            start = tbl[i].start;
            stop  = tbl[i].stop;
            reset = tbl[i].reset;
            edges(1);
            check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].mn, tbl[i].sc);
        end
        start = 1'b0;
        stop  = 1'b0;
        reset = 1'b0;

        // First tick latency and 1:02 after 248 edges
        pulse(1'b0, 1'b0, 1'b1);
        check_all("sync_clear", 2'b00, 7'd0, 6'd0);
        pulse(1'b1, 1'b0, 1'b0);
        check_all("run_entry", 2'b01, 7'd0, 6'd0);
        for (int i = 1; i < 4; i++) begin
            edges(1);
            check($sformatf("pre_tick%0d.seconds", i), 32'(seconds), 32'd0);
        end
        edges(1);
        check("first_tick.seconds", 32'(seconds), 32'd1);
        edges(244);
        check_all("run_1_02", 2'b01, 7'd1, 6'd2);

        // Pause with prescaler at 2 -> 3 on the stop edge; one edge after resume ticks
        edges(2);
        pulse(1'b0, 1'b1, 1'b0);
        check_all("paused", 2'b10, 7'd1, 6'd2);
        edges(100);
        check_all("pause_frozen", 2'b10, 7'd1, 6'd2);
        pulse(1'b1, 1'b0, 1'b0);
        check_all("resumed", 2'b01, 7'd1, 6'd2);
        edges(1);
        check_all("resume_tick", 2'b01, 7'd1, 6'd3);

        // Full-scale wrap 99:59 -> 00:00
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        edges(23992);
        check_all("at_99_58", 2'b01, 7'd99, 6'd58);
        edges(4);
        check_all("at_99_59", 2'b01, 7'd99, 6'd59);
        edges(4);
        check_all("wrap_00_00", 2'b01, 7'd0, 6'd0);
        edges(4);
        check_all("after_wrap", 2'b01, 7'd0, 6'd1);

        // Asynchronous rst_n between edges while running at 0:37
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        edges(150);
        check_all("at_0_37", 2'b01, 7'd0, 6'd37);
        rst_n = 1'b0;
        #1;
        check_all("async_abort", 2'b00, 7'd0, 6'd0);
        #1;
        rst_n = 1'b1;
        edges(3);
        check_all("post_abort", 2'b00, 7'd0, 6'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
